// File: rtl/coupler_2to4.sv
// coupler_2to4: packs pairs of 2-record beats into 4-record beats and keeps run terminators aligned.
// Optional completed-run counter enabled by defining COUPLER_RUN_COUNT_EN.
module coupler_2to4 #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [2*DATA_WIDTH-1:0] i_fifo,
  input  logic                    i_fifo_empty,
  output logic                    o_fifo_read,
  input  logic                    i_fifo_out_ready,
  output logic                    o_out_fifo_write,
  output logic [4*DATA_WIDTH-1:0] o_data,
  output logic                    o_align_err,
  output logic [31:0]             o_run_count,
  output logic                    o_dbg_state
);

  // Handshake: the upstream FIFO is first-word-fall-through; a beat is consumed in
  // any cycle where o_fifo_read is high (only when i_fifo_empty is low). Downstream
  // has no per-beat ready: o_out_fifo_write is a one-cycle enqueue strobe, and
  // i_fifo_out_ready must drop while at least two free slots remain.

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } state_t;

  if (KEY_WIDTH < 1 || KEY_WIDTH > DATA_WIDTH) begin : g_bad_key_width
    $error("coupler_2to4: KEY_WIDTH must be in 1..DATA_WIDTH");
  end

  state_t                    state_q, state_d;
  logic [2*DATA_WIDTH-1:0]   held_q;
  logic                      ready_q;
  logic                      go;
  logic                      terminator;
  logic                      held_load;
  logic                      wr_en;
  logic [4*DATA_WIDTH-1:0]   wr_data;
  logic                      align_set;
  logic                      term_wr;

  // Next-state and decode. Reset also gates go so nothing is dequeued during reset.
  always_comb begin
    terminator  = (i_fifo[DATA_WIDTH-1:0] == '0);
    go          = ready_q & ~i_fifo_empty & ~i_rst;
    state_d     = state_q;
    o_fifo_read = 1'b0;
    held_load   = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    align_set   = 1'b0;
    term_wr     = 1'b0;
    if (go) begin
      case (state_q)
        S_EMPTY: begin
          o_fifo_read = 1'b1;
          if (terminator) begin
            wr_en   = 1'b1;
            term_wr = 1'b1;
          end else begin
            held_load = 1'b1;
            state_d   = S_HALF;
          end
        end
        S_HALF: begin
          wr_en   = 1'b1;
          state_d = S_EMPTY;
          if (terminator) begin
            // Flush the held half alone; the terminator stays at the FIFO head.
            wr_data   = {{(2*DATA_WIDTH){1'b0}}, held_q};
            align_set = 1'b1;
          end else begin
            o_fifo_read = 1'b1;
            wr_data     = {i_fifo, held_q};
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= S_EMPTY;
      held_q           <= '0;
      ready_q          <= 1'b0;
      o_data           <= '0;
      o_out_fifo_write <= 1'b0;
      o_align_err      <= 1'b0;
    end else begin
      state_q          <= state_d;
      ready_q          <= i_fifo_out_ready;
      o_out_fifo_write <= wr_en;
      if (held_load) held_q <= i_fifo;
      if (wr_en)     o_data <= wr_data;
      if (align_set) o_align_err <= 1'b1;
    end
  end

`ifdef COUPLER_RUN_COUNT_EN
  logic [31:0] run_count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_count_q <= '0;
    end else if (term_wr) begin
      run_count_q <= run_count_q + 32'd1;
    end
  end

  assign o_run_count = run_count_q;
`else
  logic unused_term_wr;
  assign unused_term_wr = term_wr;
  assign o_run_count    = '0;
`endif

  assign o_dbg_state = state_q;

`ifndef SYNTHESIS
  a_read_has_data: assert property (@(posedge i_clk) disable iff (i_rst)
    o_fifo_read |-> !i_fifo_empty);
  a_write_after_ready: assert property (@(posedge i_clk) disable iff (i_rst)
    o_out_fifo_write |-> $past(ready_q));
`endif

endmodule

// File: tb/tb_coupler_2to4.sv
// Bench for coupler_2to4: table of run vectors plus hand sequences for
// backpressure, starvation, reset mid-pair and back-to-back terminators.
module tb_coupler_2to4;
  localparam int DW = 16;
  localparam int BW = 2 * DW;
  localparam int OW = 4 * DW;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [BW-1:0] i_fifo = '0;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_read;
  logic          i_fifo_out_ready = 1'b0;
  logic          o_out_fifo_write;
  logic [OW-1:0] o_data;
  logic          o_align_err;
  logic [31:0]   o_run_count;
  logic          o_dbg_state;

  coupler_2to4 #(.DATA_WIDTH(DW), .KEY_WIDTH(8)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_fifo           (i_fifo),
    .i_fifo_empty     (i_fifo_empty),
    .o_fifo_read      (o_fifo_read),
    .i_fifo_out_ready (i_fifo_out_ready),
    .o_out_fifo_write (o_out_fifo_write),
    .o_data           (o_data),
    .o_align_err      (o_align_err),
    .o_run_count      (o_run_count),
    .o_dbg_state      (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] in_q[$];
  logic [OW-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  last_wr_cyc = 0;
  int  prev_wr_cyc = 0;
  bit  rdy = 1'b1;
  bit  starve = 1'b0;
  logic last_read;

  // golden model state (used for random streams)
  logic [BW-1:0] m_held;
  bit  m_has;
  bit  m_err;
  int  m_runs;

  typedef struct {
    logic [4:0][BW-1:0] beats;
    int                 n_in;
    logic [2:0][OW-1:0] outs;
    int                 n_out;
    logic               err;
    int                 runs;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [BW-1:0] mk_beat(input int r0, input int r1);
    return {DW'(r1), DW'(r0)};
  endfunction

  function automatic logic [OW-1:0] mk_out(input int r3, input int r2, input int r1, input int r0);
    return {DW'(r3), DW'(r2), DW'(r1), DW'(r0)};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Observe outputs on the falling edge, then present the FIFO head; the
  // combinational read strobe is sampled 1ns later and pops the model FIFO.
  task automatic step();
    logic [OW-1:0] e;
    @(negedge clk);
    cyc++;
    if (o_out_fifo_write === 1'b1) begin
      wr_cnt++;
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got write of %h, required no write (cycle %0d)", o_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", o_data, e);
      end
    end
    i_fifo_out_ready = rdy;
    i_fifo_empty     = starve || (in_q.size() == 0);
    i_fifo           = (in_q.size() != 0) ? in_q[0] : '0;
    #1;
    last_read = o_fifo_read;
    if (o_fifo_read === 1'b1 && in_q.size() != 0) void'(in_q.pop_front());
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    rdy = 1'b1;
    starve = 1'b0;
    exp_q.delete();
    in_q.delete();
    in_q.push_back(mk_beat(7, 7));
    step();
    step();
    check("rst_write", OW'(o_out_fifo_write), OW'(0));
    check("rst_data", o_data, '0);
    check("rst_align", OW'(o_align_err), OW'(0));
    check("rst_runs", OW'(o_run_count), OW'(0));
    check("rst_read", OW'(last_read), OW'(0));
    check("rst_state", OW'(o_dbg_state), OW'(0));
    in_q.delete();
    i_rst = 1'b0;
    i_fifo = mk_beat(1, 1);
    i_fifo_empty = 1'b0;
    #1;
    check("read_after_rst", OW'(o_fifo_read), OW'(0));
    i_fifo_empty = 1'b1;
    m_has = 1'b0;
    m_err = 1'b0;
    m_runs = 0;
    m_held = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    check({name, "_exp_left"}, OW'(exp_q.size()), OW'(0));
    check({name, "_in_left"}, OW'(in_q.size()), OW'(0));
  endtask

  function automatic int exp_runs(input int r);
`ifdef COUPLER_RUN_COUNT_EN
    return r;
`else
    return 0 * r;
`endif
  endfunction

  task automatic model_push(input logic [BW-1:0] b);
    in_q.push_back(b);
    if (b[DW-1:0] == '0) begin
      if (m_has) begin
        exp_q.push_back({{BW{1'b0}}, m_held});
        m_err = 1'b1;
        m_has = 1'b0;
      end
      exp_q.push_back('0);
      m_runs++;
    end else if (m_has) begin
      exp_q.push_back({b, m_held});
      m_has = 1'b0;
    end else begin
      m_held = b;
      m_has = 1'b1;
    end
  endtask

  task automatic run_vec(input int k);
    string nm;
    nm = $sformatf("v%0d", k);
    do_reset();
    for (int i = 0; i < vecs[k].n_in; i++) in_q.push_back(vecs[k].beats[i]);
    for (int i = 0; i < vecs[k].n_out; i++) exp_q.push_back(vecs[k].outs[i]);
    drain(nm, 60);
    check({nm, "_align"}, OW'(o_align_err), OW'(vecs[k].err));
    check({nm, "_runs"}, OW'(o_run_count), OW'(exp_runs(vecs[k].runs)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int post_drop;
    int w0;
    int n;

    vecs[0].n_in = 5;  vecs[0].n_out = 3; vecs[0].err = 1'b0; vecs[0].runs = 1;
    vecs[0].beats[0] = mk_beat(1, 2); vecs[0].beats[1] = mk_beat(3, 4);
    vecs[0].beats[2] = mk_beat(5, 6); vecs[0].beats[3] = mk_beat(7, 8);
    vecs[0].beats[4] = mk_beat(0, 0);
    vecs[0].outs[0] = mk_out(4, 3, 2, 1); vecs[0].outs[1] = mk_out(8, 7, 6, 5);
    vecs[0].outs[2] = '0;

    vecs[1].n_in = 4;  vecs[1].n_out = 3; vecs[1].err = 1'b1; vecs[1].runs = 1;
    vecs[1].beats[0] = mk_beat(1, 2); vecs[1].beats[1] = mk_beat(3, 4);
    vecs[1].beats[2] = mk_beat(5, 6); vecs[1].beats[3] = mk_beat(0, 0);
    vecs[1].outs[0] = mk_out(4, 3, 2, 1); vecs[1].outs[1] = mk_out(0, 0, 6, 5);
    vecs[1].outs[2] = '0;

    vecs[2].n_in = 2;  vecs[2].n_out = 2; vecs[2].err = 1'b0; vecs[2].runs = 2;
    vecs[2].beats[0] = mk_beat(0, 0); vecs[2].beats[1] = mk_beat(0, 0);
    vecs[2].outs[0] = '0; vecs[2].outs[1] = '0;

    vecs[3].n_in = 1;  vecs[3].n_out = 1; vecs[3].err = 1'b0; vecs[3].runs = 1;
    vecs[3].beats[0] = mk_beat(0, 'h55);
    vecs[3].outs[0] = '0;

    vecs[4].n_in = 2;  vecs[4].n_out = 2; vecs[4].err = 1'b1; vecs[4].runs = 1;
    vecs[4].beats[0] = mk_beat(9, 0); vecs[4].beats[1] = mk_beat(0, 0);
    vecs[4].outs[0] = mk_out(0, 0, 0, 9); vecs[4].outs[1] = '0;

    vecs[5].n_in = 2;  vecs[5].n_out = 1; vecs[5].err = 1'b0; vecs[5].runs = 0;
    vecs[5].beats[0] = mk_beat('hA, 'hB); vecs[5].beats[1] = mk_beat('hC, 'hD);
    vecs[5].outs[0] = mk_out('hD, 'hC, 'hB, 'hA);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Backpressure: random stream, ready low for 5 cycles mid-stream.
    do_reset();
    for (int i = 0; i < 16; i++)
      model_push(mk_beat($urandom_range(1, 255), $urandom_range(0, 255)));
    model_push(mk_beat(0, 0));
    post_drop = 0;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      rdy = !(n >= 8 && n < 13);
      w0 = wr_cnt;
      step();
      if (n >= 9 && n <= 13) post_drop += wr_cnt - w0;
      n++;
    end
    rdy = 1'b1;
    n_tests++;
    if (post_drop > 2) begin
      n_fail++;
      $display("FAIL bp_writes_after_drop: got %0d, required at most 2", post_drop);
    end
    drain("bp", 40);
    check("bp_align", OW'(o_align_err), OW'(m_err));
    check("bp_runs", OW'(o_run_count), OW'(exp_runs(m_runs)));

    // Starved input while a half beat is held.
    do_reset();
    in_q.push_back(mk_beat(1, 2));
    n = 0;
    while (in_q.size() != 0 && n < 10) begin step(); n++; end
    starve = 1'b1;
    in_q.push_back(mk_beat(3, 4));
    exp_q.push_back(mk_out(4, 3, 2, 1));
    repeat (10) begin
      step();
      check("starve_read", OW'(last_read), OW'(0));
      check("starve_write", OW'(o_out_fifo_write), OW'(0));
    end
    check("starve_state", OW'(o_dbg_state), OW'(1));
    starve = 1'b0;
    drain("starve", 20);

    // Reset mid-pair drops the held half.
    do_reset();
    in_q.push_back(mk_beat(9, 10));
    n = 0;
    while (in_q.size() != 0 && n < 10) begin step(); n++; end
    i_rst = 1'b1;
    step();
    check("midrst_write", OW'(o_out_fifo_write), OW'(0));
    check("midrst_data", o_data, '0);
    check("midrst_state", OW'(o_dbg_state), OW'(0));
    check("midrst_read", OW'(last_read), OW'(0));
    i_rst = 1'b0;
    in_q.push_back(mk_beat(1, 2));
    in_q.push_back(mk_beat(3, 4));
    exp_q.push_back(mk_out(4, 3, 2, 1));
    drain("midrst", 20);

    // Back-to-back terminators produce writes on consecutive cycles.
    do_reset();
    in_q.push_back(mk_beat(0, 0));
    in_q.push_back(mk_beat(0, 0));
    exp_q.push_back('0);
    exp_q.push_back('0);
    w0 = wr_cnt;
    drain("b2b", 20);
    check("b2b_count", OW'(wr_cnt - w0), OW'(2));
    check("b2b_gap", OW'(last_wr_cyc - prev_wr_cyc), OW'(1));
    check("b2b_runs", OW'(o_run_count), OW'(exp_runs(2)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
